// File: rtl/wb_mem_responder.sv
// Wishbone B3 slave backed by on-chip byte-lane memory: classic and linear burst
// cycles, programmable wait states, out-of-range error termination, beat counters.
module wb_mem_responder #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [29:0]     wb_addr_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    input  logic [3:0]      cfg_wait,
    output logic [15:0]     wr_cnt,
    output logic [15:0]     rd_cnt,
    output logic [15:0]     err_cnt
);
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

    state_t      state_reg, state_next;
    logic [29:0] addr_reg, addr_next;
    logic        we_reg, we_next;
    logic [2:0]  cti_reg, cti_next;
    logic [3:0]  wait_reg, wait_next;
    logic [15:0] wr_cnt_reg, rd_cnt_reg, err_cnt_reg;

    logic [3:0]  wait_load;
    logic [29:0] addr_inc;
    logic        burst_linear;
    logic        burst_more;
    logic        wr_en;

    assign wait_load = (cfg_wait > 4'(MAX_WAIT)) ? 4'(MAX_WAIT) : cfg_wait;
    assign addr_inc  = addr_reg + 30'd1;
    // Every burst type steps linearly; wrap modes are deliberately not honoured.
    assign burst_linear = (wb_bte_i == 2'b00) || (wb_bte_i != 2'b00);
    assign burst_more   = burst_linear && (cti_reg == 3'b010) && (wb_cti_i != 3'b111);

    assign wb_ack_o = (state_reg == ACK) && wb_cyc_i && wb_stb_i;
    assign wb_err_o = (state_reg == ERR);
    assign wr_en    = wb_ack_o && we_reg;
    assign wr_cnt   = wr_cnt_reg;
    assign rd_cnt   = rd_cnt_reg;
    assign err_cnt  = err_cnt_reg;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            cti_reg   <= 3'b000;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            we_reg    <= we_next;
            cti_reg   <= cti_next;
            wait_reg  <= wait_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        we_next    = we_reg;
        cti_next   = cti_reg;
        wait_next  = wait_reg;
        case (state_reg)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_next = wb_addr_i;
                    we_next   = wb_we_i;
                    cti_next  = wb_cti_i;
                    wait_next = wait_load;
                    if (|wb_addr_i[29:AW])   state_next = ERR;
                    else if (wait_load == 0) state_next = ACK;
                    else                     state_next = WAIT;
                end
            end
            WAIT: begin
                if (!wb_cyc_i)          state_next = IDLE;
                else if (wait_reg <= 1) state_next = ACK;
                else                    wait_next  = wait_reg - 4'd1;
            end
            ACK: begin
                if (!wb_cyc_i) begin
                    state_next = IDLE;
                end else if (wb_stb_i) begin
                    if (burst_more) begin
                        addr_next = addr_inc;
                        wait_next = wait_load;
                        if (|addr_inc[29:AW])    state_next = ERR;
                        else if (wait_load == 0) state_next = ACK;
                        else                     state_next = WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_cnt_reg  <= '0;
            rd_cnt_reg  <= '0;
            err_cnt_reg <= '0;
        end else begin
            if (wr_en && wr_cnt_reg != 16'hFFFF) wr_cnt_reg <= wr_cnt_reg + 16'd1;
            if (wb_ack_o && !we_reg && rd_cnt_reg != 16'hFFFF) rd_cnt_reg <= rd_cnt_reg + 16'd1;
            if (state_reg == ERR && err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end

    // One RAM per byte lane; the read port follows addr_next so data is ready with ack.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q_reg;

            always_ff @(posedge wb_clk_i) begin
                if (wr_en && wb_sel_i[gi])
                    lane_mem[addr_reg[AW-1:0]] <= wb_dat_i[gi*8 +: 8];
            end

            always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
                if (wb_rst_i) lane_q_reg <= 8'h00;
                else          lane_q_reg <= lane_mem[addr_next[AW-1:0]];
            end

            assign wb_dat_o[gi*8 +: 8] = lane_q_reg;
        end
    endgenerate
endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: read data checked against a scoreboard queue,
// latency, burst spacing, error termination, abort, counters and async reset.
module tb_wb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [29:0] wb_addr = '0;
    logic [3:0]  wb_sel = 4'hF;
    logic [31:0] wb_dat = '0;
    logic [2:0]  wb_cti = 3'b000;
    logic [1:0]  wb_bte = 2'b00;
    logic [31:0] wb_dat_o;
    logic        wb_ack, wb_err;
    logic [3:0]  cfg_wait = 4'd0;
    logic [15:0] wr_cnt, rd_cnt, err_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wbuf[16];

    wb_mem_responder dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
        .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_sel_i(wb_sel), .wb_dat_i(wb_dat),
        .wb_cti_i(wb_cti), .wb_bte_i(wb_bte), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack),
        .wb_err_o(wb_err), .cfg_wait(cfg_wait), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Runs n beats starting at addr; read data is compared against exp_q as acks arrive.
    task automatic xfer(input logic we, input logic [29:0] addr, input int n,
                        input logic [3:0] sel, input int budget,
                        output int acks, output int errs, output int first_lat, output int span);
        int beat = 0;
        int edges = 0;
        int first_e = -1;
        int last_e = -1;
        logic [31:0] exp;
        acks = 0;
        errs = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_sel = sel;
        while (edges < budget) begin
            wb_dat = wbuf[beat];
            wb_cti = (n == 1) ? 3'b000 : ((beat == n - 1) ? 3'b111 : 3'b010);
            #1;
            if (wb_ack) begin
                acks++;
                if (first_e < 0) first_e = edges;
                last_e = edges;
                if (!we) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $error("FAIL rd_unexpected observed=%h expected=none", wb_dat_o);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("rd_data", wb_dat_o, exp);
                    end
                end
                beat++;
            end
            if (wb_err) errs++;
            @(posedge clk); #1;
            edges++;
            if (beat == n || errs != 0) break;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_cti = 3'b000;
        first_lat = first_e;
        span = (first_e < 0) ? 0 : last_e - first_e + 1;
        $display("xfer we=%0b addr=%h beats=%0d acks=%0d errs=%0d lat=%0d span=%0d",
                 we, addr, n, acks, errs, first_lat, span);
    endtask

    initial begin
        int acks, errs, lat, span;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(wb_ack), 32'd0);
        chk("rst_err", 32'(wb_err), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_cnts", {wr_cnt, rd_cnt} | 32'(err_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Classic write/read, no wait states
        cfg_wait = 4'd0;
        wbuf[0] = 32'hDEADBEEF;
        xfer(1'b1, 30'h004, 1, 4'hF, 40, acks, errs, lat, span);
        chk("wr0_acks", 32'(acks), 32'd1);
        chk("wr0_lat", 32'(lat), 32'd1);
        exp_q.push_back(32'hDEADBEEF);
        xfer(1'b0, 30'h004, 1, 4'hF, 40, acks, errs, lat, span);
        chk("rd0_lat", 32'(lat), 32'd1);
        chk("cnt_wr1", 32'(wr_cnt), 32'd1);
        chk("cnt_rd1", 32'(rd_cnt), 32'd1);

        // Wait states and byte lane merge
        cfg_wait = 4'd3;
        wbuf[0] = 32'hAABBCCDD;
        xfer(1'b1, 30'h010, 1, 4'hF, 40, acks, errs, lat, span);
        chk("wr3_lat", 32'(lat), 32'd4);
        wbuf[0] = 32'h11223344;
        xfer(1'b1, 30'h010, 1, 4'b0101, 40, acks, errs, lat, span);
        exp_q.push_back(32'hAA22CC44);
        xfer(1'b0, 30'h010, 1, 4'hF, 40, acks, errs, lat, span);
        chk("rd3_lat", 32'(lat), 32'd4);

        // 8-beat bursts back to back
        cfg_wait = 4'd0;
        for (int i = 0; i < 8; i++) wbuf[i] = 32'(i);
        xfer(1'b1, 30'h3F0, 8, 4'hF, 40, acks, errs, lat, span);
        chk("bw_acks", 32'(acks), 32'd8);
        chk("bw_span", 32'(span), 32'd8);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
        xfer(1'b0, 30'h3F0, 8, 4'hF, 40, acks, errs, lat, span);
        chk("br_acks", 32'(acks), 32'd8);
        chk("br_span", 32'(span), 32'd8);
        chk("cnt_wr11", 32'(wr_cnt), 32'd11);
        chk("cnt_rd10", 32'(rd_cnt), 32'd10);

        // Out-of-range classic read, then bursts running off the end of memory
        xfer(1'b0, 30'h400, 1, 4'hF, 40, acks, errs, lat, span);
        chk("oor_acks", 32'(acks), 32'd0);
        chk("oor_errs", 32'(errs), 32'd1);
        chk("oor_err_low", 32'(wb_err), 32'd0);
        chk("cnt_err1", 32'(err_cnt), 32'd1);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0000 + 32'(i);
        xfer(1'b1, 30'h3FE, 4, 4'hF, 40, acks, errs, lat, span);
        chk("bwe_acks", 32'(acks), 32'd2);
        chk("bwe_errs", 32'(errs), 32'd1);
        exp_q.push_back(32'hC0DE0000);
        exp_q.push_back(32'hC0DE0001);
        xfer(1'b0, 30'h3FE, 4, 4'hF, 40, acks, errs, lat, span);
        chk("bre_acks", 32'(acks), 32'd2);
        chk("bre_errs", 32'(errs), 32'd1);
        chk("cnt_err3", 32'(err_cnt), 32'd3);
        chk("cnt_wr13", 32'(wr_cnt), 32'd13);

        // Abort by dropping cyc during wait states
        wbuf[0] = 32'h0;
        xfer(1'b1, 30'h020, 1, 4'hF, 40, acks, errs, lat, span);
        cfg_wait = 4'd5;
        wbuf[0] = 32'hFFFFFFFF;
        xfer(1'b1, 30'h020, 1, 4'hF, 2, acks, errs, lat, span);
        chk("abort_acks", 32'(acks), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_ack_low", 32'(wb_ack), 32'd0);
        chk("cnt_wr14", 32'(wr_cnt), 32'd14);
        cfg_wait = 4'd0;
        exp_q.push_back(32'h0);
        xfer(1'b0, 30'h020, 1, 4'hF, 40, acks, errs, lat, span);
        chk("abort_rd_acks", 32'(acks), 32'd1);

        // Asynchronous reset while ack is high in a burst
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 30'h3F0; wb_cti = 3'b010;
        @(posedge clk); #1;
        chk("mid_ack_high", 32'(wb_ack), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ack", 32'(wb_ack), 32'd0);
        chk("arst_err", 32'(wb_err), 32'd0);
        chk("arst_dat", wb_dat_o, 32'd0);
        chk("arst_cnts", {wr_cnt, rd_cnt} | 32'(err_cnt), 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = 3'b000;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(32'hDEADBEEF);
        xfer(1'b0, 30'h004, 1, 4'hF, 40, acks, errs, lat, span);
        chk("post_rst_lat", 32'(lat), 32'd1);
        chk("post_rst_rd", 32'(rd_cnt), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
